mbist_march_ctrl: RTL

Memory built-in self-test controller that runs a March C- sequence on one single-port memory of the fault_mem type. It drives the memory write_read, address and wdata pins and compares returned rdata against expected data. It reports pass/fail, the first failing location and a saturating fail count. It sits between the top-level test control and the memory under test, so a fault-injected memory can be swapped in without changing this block.

---
 rtl/mbist_pkg.sv | 34 +++
 rtl/mbist_cmp_pipe.sv | 67 ++++++
 rtl/mbist_march_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mbist_pkg.sv
// Shared definitions for the March C- MBIST controller: element indices,
// FSM encoding and per-element behaviour tables.
package mbist_pkg;

  localparam logic [2:0] E0 = 3'd0;
  localparam logic [2:0] E1 = 3'd1;
  localparam logic [2:0] E2 = 3'd2;
  localparam logic [2:0] E3 = 3'd3;
  localparam logic [2:0] E4 = 3'd4;
  localparam logic [2:0] E5 = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Bit i of each table describes element Ei.
  localparam logic [5:0] ELEM_DOWN   = 6'b011000;  // descending address order
  localparam logic [5:0] ELEM_TWO_OP = 6'b011110;  // read then write per address
  localparam logic [5:0] ELEM_HAS_WR = 6'b011111;  // element contains a write
  localparam logic [5:0] ELEM_RD_ONE = 6'b010100;  // reads expect all ones
  localparam logic [5:0] ELEM_WR_ONE = 6'b001010;  // writes store all ones

  function automatic logic elem_bit(input logic [5:0] tbl, input logic [2:0] e);
    logic r;
    r = 1'b0;
    if (e <= E5) r = tbl[e];
    return r;
  endfunction

endpackage

// File: rtl/mbist_cmp_pipe.sv
// Read-compare pipeline: aligns each read's tag with the returned data two
// cycles later, counts miscompares and captures the first one.
module mbist_cmp_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push_valid,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [2:0]            push_elem,
  input  logic [DATA_WIDTH-1:0] push_exp,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_syndrome
);

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            elem;
    logic [DATA_WIDTH-1:0] exp_data;
  } tag_t;

  tag_t s1_q, s2_q;
  logic first_q;
  logic miscompare;

  assign miscompare = s2_q.valid && (rdata != s2_q.exp_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q          <= '0;
      s2_q          <= '0;
      first_q       <= 1'b0;
      fail_count    <= '0;
      fail_addr     <= '0;
      fail_elem     <= '0;
      fail_syndrome <= '0;
    end else if (clear) begin
      s1_q          <= '0;
      s2_q          <= '0;
      first_q       <= 1'b0;
      fail_count    <= '0;
      fail_addr     <= '0;
      fail_elem     <= '0;
      fail_syndrome <= '0;
    end else begin
      s1_q <= {push_valid, push_addr, push_elem, push_exp};
      s2_q <= s1_q;
      if (miscompare) begin
        if (fail_count != '1) fail_count <= fail_count + CNT_WIDTH'(1);
        if (!first_q) begin
          first_q       <= 1'b1;
          fail_addr     <= s2_q.addr;
          fail_elem     <= s2_q.elem;
          fail_syndrome <= rdata ^ s2_q.exp_data;
        end
      end
    end
  end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller: sequences the six March elements over one
// single-port memory and reports pass/fail with first-failure capture.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_syndrome,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY - 1);

  // Handshake: start is a single-cycle pulse, accepted only in IDLE or DONE;
  // busy is high from the cycle after acceptance until done rises, done then
  // holds (with pass) until the next accepted start. start while busy is ignored.
  state_t                state_q, state_d;
  logic [2:0]            elem_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  phase_q;
  logic                  drain_q;
  logic                  accept, two_op, down, last_op, last_addr;
  logic                  op_write, op_read;

  assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign two_op    = elem_bit(ELEM_TWO_OP, elem_q);
  assign down      = elem_bit(ELEM_DOWN, elem_q);
  assign last_op   = !two_op || phase_q;
  assign last_addr = down ? (addr_q == '0) : (addr_q == LAST_ADDR);
  assign op_write  = (state_q == S_RUN) && (two_op ? phase_q : elem_bit(ELEM_HAS_WR, elem_q));
  assign op_read   = (state_q == S_RUN) && !op_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (accept) state_d = S_SETUP;
      S_SETUP:        state_d = S_RUN;
      S_RUN:          if (last_op && last_addr) state_d = (elem_q == E5) ? S_DRAIN : S_SETUP;
      S_DRAIN:        if (drain_q) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Address moves only after the final operation at an address, and never
  // steps past either end of the tested range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_q  <= E0;
      addr_q  <= '0;
      phase_q <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            elem_q  <= E0;
            phase_q <= 1'b0;
            drain_q <= 1'b0;
          end
        end
        S_SETUP: begin
          addr_q  <= down ? LAST_ADDR : '0;
          phase_q <= 1'b0;
        end
        S_RUN: begin
          if (!last_op) begin
            phase_q <= 1'b1;
          end else begin
            phase_q <= 1'b0;
            if (!last_addr)          addr_q <= down ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
            else if (elem_q != E5)   elem_q <= elem_q + 3'd1;
          end
        end
        S_DRAIN: drain_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign busy           = (state_q == S_SETUP) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);
  assign pass           = done && (fail_count == '0);
  assign mem_write_read = op_write;
  assign mem_address    = addr_q;
  // Write data is set up in SETUP and held for the whole element.
  assign mem_wdata      = ((state_q == S_SETUP) || (state_q == S_RUN))
                          ? {DATA_WIDTH{elem_bit(ELEM_WR_ONE, elem_q)}} : '0;

  mbist_cmp_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cmp_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (accept),
    .push_valid   (op_read),
    .push_addr    (addr_q),
    .push_elem    (elem_q),
    .push_exp     ({DATA_WIDTH{elem_bit(ELEM_RD_ONE, elem_q)}}),
    .rdata        (mem_rdata),
    .fail_count   (fail_count),
    .fail_addr    (fail_addr),
    .fail_elem    (fail_elem),
    .fail_syndrome(fail_syndrome)
  );

endmodule
